// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory responder: access sizes, FSM states
// and the size/alignment legality check.
package dmem_pkg;

  localparam logic [1:0] SIZE_B = 2'b00;
  localparam logic [1:0] SIZE_H = 2'b01;
  localparam logic [1:0] SIZE_W = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    WAIT = 2'b01,
    RESP = 2'b10
  } state_e;

  // True when the size code is illegal or the byte offset does not suit it.
  function automatic logic align_err(input logic [1:0] size, input logic [1:0] off);
    logic err;
    err = 1'b1;
    case (size)
      SIZE_B:  err = 1'b0;
      SIZE_H:  err = off[0];
      SIZE_W:  err = |off;
      default: err = 1'b1;
    endcase
    return err;
  endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Combinational lane steering: merges store data into the old word and
// extracts/extends load data from a word, little-endian.
module dmem_lane_align
  import dmem_pkg::*;
(
  input  logic [31:0] i_old_word,
  input  logic [31:0] i_wdata,
  input  logic [1:0]  i_size,
  input  logic [1:0]  i_off,
  input  logic        i_unsigned,
  output logic [31:0] o_new_word,
  output logic [31:0] o_load_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_old_word[{i_off, 3'b000} +: 8];
  assign w_half = i_old_word[{i_off[1], 4'b0000} +: 16];

  // Store merge and load extension, selected by access size.
  always_comb begin
    // NOTE: both outputs get a default first so no path leaves them unassigned (no latch).
    o_new_word  = i_old_word;
    o_load_data = '0;
    case (i_size)
      SIZE_B: begin
        o_new_word[{i_off, 3'b000} +: 8] = i_wdata[7:0];
        o_load_data = i_unsigned ? {24'b0, w_byte} : {{24{w_byte[7]}}, w_byte};
      end
      SIZE_H: begin
        o_new_word[{i_off[1], 4'b0000} +: 16] = i_wdata[15:0];
        o_load_data = i_unsigned ? {16'b0, w_half} : {{16{w_half[15]}}, w_half};
      end
      SIZE_W: begin
        o_new_word  = i_wdata;
        o_load_data = i_old_word;
      end
      default: begin
        o_new_word  = i_old_word;
        o_load_data = '0;
      end
    endcase
  end

endmodule

// File: rtl/data_mem_responder.sv
// Data-memory responder: accepts one load/store at a time, waits WAIT_STATES
// cycles, commits to the word array on the edge entering RESP and returns a
// registered one-cycle response strobe with data or an error flag.
module data_mem_responder
  import dmem_pkg::*;
#(
  parameter int unsigned MEM_WORDS   = 1024,
  parameter int unsigned WAIT_STATES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_i,
  input  logic        we_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] wdata_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic        ready_o,
  output logic        rvalid_o,
  output logic [31:0] rdata_o,
  output logic        err_o
);

  localparam int unsigned IDX_W   = (MEM_WORDS > 1) ? $clog2(MEM_WORDS) : 1;
  localparam logic [3:0]  WS_LOAD = 4'(WAIT_STATES);

  state_e            r_state;
  state_e            w_state_nxt;
  logic [3:0]        r_cnt;
  logic              r_we;
  logic              r_uns;
  logic              r_err;
  logic [1:0]        r_size;
  logic [1:0]        r_off;
  logic [IDX_W-1:0]  r_idx;
  logic [31:0]       r_wdata;
  logic [31:0]       r_ldata;
  logic              r_rvalid;
  logic              r_err_o;
  logic [31:0]       r_rdata;
  logic [31:0]       r_mem [MEM_WORDS];

  logic              w_idle;
  logic              w_accept;
  logic              w_req_err;
  logic              w_commit;
  logic              w_sel_we;
  logic              w_sel_uns;
  logic [1:0]        w_sel_size;
  logic [1:0]        w_sel_off;
  logic [IDX_W-1:0]  w_sel_idx;
  logic [31:0]       w_sel_wdata;
  logic [31:0]       w_old_word;
  logic [31:0]       w_new_word;
  logic [31:0]       w_load_data;

  assign w_idle    = (r_state == IDLE);
  assign ready_o   = w_idle;
  assign w_accept  = req_i && w_idle;
  assign w_req_err = align_err(size_i, addr_i[1:0]) ||
                     ({2'b00, addr_i[31:2]} >= MEM_WORDS);

  // With zero wait states the commit edge is the acceptance edge, so the
  // access must use the live inputs; otherwise it uses the latched request.
  assign w_sel_we    = w_idle ? we_i                   : r_we;
  assign w_sel_uns   = w_idle ? unsigned_i             : r_uns;
  assign w_sel_size  = w_idle ? size_i                 : r_size;
  assign w_sel_off   = w_idle ? addr_i[1:0]            : r_off;
  assign w_sel_idx   = w_idle ? addr_i[IDX_W+1:2]      : r_idx;
  assign w_sel_wdata = w_idle ? wdata_i                : r_wdata;

  // Commit on the edge entering RESP, except for requests that failed the check.
  assign w_commit = (w_state_nxt == RESP) && !(w_idle && w_req_err);

  assign w_old_word = r_mem[w_sel_idx];

  dmem_lane_align u_lane_align (
    .i_old_word  (w_old_word),
    .i_wdata     (w_sel_wdata),
    .i_size      (w_sel_size),
    .i_off       (w_sel_off),
    .i_unsigned  (w_sel_uns),
    .o_new_word  (w_new_word),
    .o_load_data (w_load_data)
  );

  // Next-state decode.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (req_i) begin
          if (w_req_err || (WAIT_STATES == 0)) w_state_nxt = RESP;
          else                                 w_state_nxt = WAIT;
        end
      end
      WAIT:    if (r_cnt == 4'd1) w_state_nxt = RESP;
      RESP:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // State, request latch, wait counter, load capture and registered response.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_we     <= 1'b0;
      r_uns    <= 1'b0;
      r_err    <= 1'b0;
      r_size   <= '0;
      r_off    <= '0;
      r_idx    <= '0;
      r_wdata  <= '0;
      r_ldata  <= '0;
      r_rvalid <= 1'b0;
      r_err_o  <= 1'b0;
      r_rdata  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples pre-edge values.
      r_state <= w_state_nxt;
      if (w_accept) begin
        r_we    <= we_i;
        r_uns   <= unsigned_i;
        r_err   <= w_req_err;
        r_size  <= size_i;
        r_off   <= addr_i[1:0];
        r_idx   <= addr_i[IDX_W+1:2];
        r_wdata <= wdata_i;
        r_cnt   <= w_req_err ? 4'd0 : WS_LOAD;
      end else if (r_state == WAIT) begin
        r_cnt <= r_cnt - 4'd1;
      end
      if (w_commit) begin
        r_ldata <= w_sel_we ? 32'd0 : w_load_data;
      end
      r_rvalid <= (r_state == RESP);
      r_err_o  <= (r_state == RESP) && r_err;
      r_rdata  <= ((r_state == RESP) && !r_err) ? r_ldata : 32'd0;
    end
  end

  // Array write on the commit edge; only selected lanes change.
  always_ff @(posedge clk) begin
    // NOTE: the array is deliberately not reset; contents survive rst.
    if (w_commit && w_sel_we) begin
      r_mem[w_sel_idx] <= w_new_word;
    end
  end

  assign rvalid_o = r_rvalid;
  assign rdata_o  = r_rdata;
  assign err_o    = r_err_o;

endmodule

// File: tb/tb_data_mem_responder.sv
// Bench for data_mem_responder: table of directed requests against a
// WAIT_STATES=1 instance, plus hand sequences for back-to-back traffic on a
// WAIT_STATES=0 instance and reset in the middle of a request.
module tb_data_mem_responder;
  import dmem_pkg::*;

  logic        clk;
  logic        rst;
  logic        req_i;
  logic        we_i;
  logic [31:0] addr_i;
  logic [31:0] wdata_i;
  logic [1:0]  size_i;
  logic        unsigned_i;

  logic        ready1, rvalid1, err1;
  logic [31:0] rdata1;
  logic        ready0, rvalid0, err0;
  logic [31:0] rdata0;

  int n_checks;
  int n_errors;

  data_mem_responder #(.MEM_WORDS(1024), .WAIT_STATES(1)) u_dut1 (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .size_i(size_i), .unsigned_i(unsigned_i),
    .ready_o(ready1), .rvalid_o(rvalid1), .rdata_o(rdata1), .err_o(err1)
  );

  data_mem_responder #(.MEM_WORDS(1024), .WAIT_STATES(0)) u_dut0 (
    .clk(clk), .rst(rst), .req_i(req_i), .we_i(we_i), .addr_i(addr_i),
    .wdata_i(wdata_i), .size_i(size_i), .unsigned_i(unsigned_i),
    .ready_o(ready0), .rvalid_o(rvalid0), .rdata_o(rdata0), .err_o(err0)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    string       name;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  vec_t vecs[$];

  function automatic void add(input string name, input logic we, input logic [31:0] addr,
                              input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                              input logic [31:0] exp_rdata, input logic exp_err);
    vec_t v;
    v.name = name; v.we = we; v.addr = addr; v.wdata = wdata; v.size = size;
    v.uns = uns; v.exp_rdata = exp_rdata; v.exp_err = exp_err;
    vecs.push_back(v);
  endfunction

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    end
  endtask

  // Issue one request to the selected instance and check latency, data and error.
  task automatic do_req(input string name, input logic we, input logic [31:0] addr,
                        input logic [31:0] wdata, input logic [1:0] size, input logic uns,
                        input logic [31:0] exp_rdata, input logic exp_err, input bit use0);
    int k;
    int lat;
    int exp_lat;
    bit seen;
    @(negedge clk);
    k = 0;
    while (!(use0 ? ready0 : ready1) && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!(use0 ? ready0 : ready1)) begin
      check({name, " ready_timeout"}, 32'd0, 32'd1);
      return;
    end
    req_i = 1'b1; we_i = we; addr_i = addr; wdata_i = wdata; size_i = size; unsigned_i = uns;
    @(posedge clk);
    @(negedge clk);
    // Scramble the inputs: the request must already be latched.
    req_i = 1'b0; we_i = ~we; addr_i = ~addr; wdata_i = ~wdata; size_i = ~size; unsigned_i = ~uns;
    seen = 1'b0;
    lat = -1;
    for (int c = 0; c < 25; c++) begin
      if (use0 ? rvalid0 : rvalid1) begin
        seen = 1'b1;
        lat = c;
        break;
      end
      @(negedge clk);
    end
    exp_lat = (exp_err || use0) ? 1 : 2;
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    if (seen) begin
      check({name, " rdata"}, use0 ? rdata0 : rdata1, exp_rdata);
      check({name, " err"}, {31'd0, use0 ? err0 : err1}, {31'd0, exp_err});
      @(negedge clk);
      check({name, " rvalid_one_cycle"}, {31'd0, use0 ? rvalid0 : rvalid1}, 32'd0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_checks = 0;
    n_errors = 0;
    rst = 1'b0;
    req_i = 1'b0; we_i = 1'b0; addr_i = '0; wdata_i = '0; size_i = SIZE_W; unsigned_i = 1'b0;

    // Reset state.
    repeat (2) @(negedge clk);
    check("reset ready1", {31'd0, ready1}, 32'd1);
    check("reset ready0", {31'd0, ready0}, 32'd1);
    check("reset rvalid", {31'd0, rvalid1}, 32'd0);
    check("reset rdata", rdata1, 32'd0);
    check("reset err", {31'd0, err1}, 32'd0);
    rst = 1'b1;

    //   name         we    addr          wdata          size    uns   exp_rdata      err
    add("sw_10",      1'b1, 32'h0000_0010, 32'hDEADBEEF, SIZE_W, 1'b0, 32'h0000_0000, 1'b0);
    add("lw_10",      1'b0, 32'h0000_0010, 32'h0,        SIZE_W, 1'b0, 32'hDEADBEEF, 1'b0);
    add("sw_20",      1'b1, 32'h0000_0020, 32'h11223344, SIZE_W, 1'b0, 32'h0000_0000, 1'b0);
    add("sb_22",      1'b1, 32'h0000_0022, 32'h123456AA, SIZE_B, 1'b0, 32'h0000_0000, 1'b0);
    add("lw_20",      1'b0, 32'h0000_0020, 32'h0,        SIZE_W, 1'b0, 32'h11AA3344, 1'b0);
    add("lb_22",      1'b0, 32'h0000_0022, 32'h0,        SIZE_B, 1'b0, 32'hFFFFFFAA, 1'b0);
    add("lbu_22",     1'b0, 32'h0000_0022, 32'h0,        SIZE_B, 1'b1, 32'h000000AA, 1'b0);
    add("sw_30",      1'b1, 32'h0000_0030, 32'hCAFE1234, SIZE_W, 1'b0, 32'h0000_0000, 1'b0);
    add("sh_32",      1'b1, 32'h0000_0032, 32'h55558001, SIZE_H, 1'b0, 32'h0000_0000, 1'b0);
    add("lh_32",      1'b0, 32'h0000_0032, 32'h0,        SIZE_H, 1'b0, 32'hFFFF8001, 1'b0);
    add("lhu_32",     1'b0, 32'h0000_0032, 32'h0,        SIZE_H, 1'b1, 32'h00008001, 1'b0);
    add("lw_30",      1'b0, 32'h0000_0030, 32'h0,        SIZE_W, 1'b0, 32'h80011234, 1'b0);
    add("lh_30",      1'b0, 32'h0000_0030, 32'h0,        SIZE_H, 1'b0, 32'h00001234, 1'b0);
    add("sw_40",      1'b1, 32'h0000_0040, 32'h01020304, SIZE_W, 1'b0, 32'h0000_0000, 1'b0);
    add("sw_41_err",  1'b1, 32'h0000_0041, 32'hFFFFFFFF, SIZE_W, 1'b0, 32'h0000_0000, 1'b1);
    add("sh_43_err",  1'b1, 32'h0000_0043, 32'hFFFFFFFF, SIZE_H, 1'b0, 32'h0000_0000, 1'b1);
    add("s11_40_err", 1'b1, 32'h0000_0040, 32'hFFFFFFFF, 2'b11,  1'b0, 32'h0000_0000, 1'b1);
    add("lh_41_err",  1'b0, 32'h0000_0041, 32'h0,        SIZE_H, 1'b0, 32'h0000_0000, 1'b1);
    add("sw_oor_err", 1'b1, 32'h0000_1000, 32'hFFFFFFFF, SIZE_W, 1'b0, 32'h0000_0000, 1'b1);
    add("lw_oor_err", 1'b0, 32'h0000_1000, 32'h0,        SIZE_W, 1'b0, 32'h0000_0000, 1'b1);
    add("lw_40",      1'b0, 32'h0000_0040, 32'h0,        SIZE_W, 1'b0, 32'h01020304, 1'b0);
    add("lb_43",      1'b0, 32'h0000_0043, 32'h0,        SIZE_B, 1'b0, 32'h00000001, 1'b0);
    add("lb_40",      1'b0, 32'h0000_0040, 32'h0,        SIZE_B, 1'b0, 32'h00000004, 1'b0);
    add("sw_ffc",     1'b1, 32'h0000_0FFC, 32'h0BADF00D, SIZE_W, 1'b0, 32'h0000_0000, 1'b0);
    add("lw_ffc",     1'b0, 32'h0000_0FFC, 32'h0,        SIZE_W, 1'b0, 32'h0BADF00D, 1'b0);

    for (int i = 0; i < vecs.size(); i++) begin
      do_req(vecs[i].name, vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].size,
             vecs[i].uns, vecs[i].exp_rdata, vecs[i].exp_err, 1'b0);
    end

    // Back-to-back on the zero-wait instance with req_i held high.
    @(negedge clk);
    while (!(ready0 && ready1)) @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h8; wdata_i = 32'hA5A5A5A5; size_i = SIZE_W; unsigned_i = 1'b0;
    for (int n = 1; n <= 6; n++) begin
      @(negedge clk);
      check($sformatf("b2b ready0 n=%0d", n), {31'd0, ready0}, {31'd0, (n % 2) == 0});
      check($sformatf("b2b rvalid0 n=%0d", n), {31'd0, rvalid0}, {31'd0, (n % 2) == 0});
    end
    req_i = 1'b0;
    do_req("ws0_lw_08", 1'b0, 32'h8, 32'h0, SIZE_W, 1'b0, 32'hA5A5A5A5, 1'b0, 1'b1);

    // Reset during WAIT of a store: the store must not land.
    do_req("sw_50", 1'b1, 32'h50, 32'h12345678, SIZE_W, 1'b0, 32'h0, 1'b0, 1'b0);
    @(negedge clk);
    while (!ready1) @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h50; wdata_i = 32'hCAFEF00D; size_i = SIZE_W;
    @(posedge clk);
    @(negedge clk);
    req_i = 1'b0;
    check("mid ready1 in wait", {31'd0, ready1}, 32'd0);
    rst = 1'b0;
    #1;
    check("mid reset ready1", {31'd0, ready1}, 32'd1);
    check("mid reset rvalid1", {31'd0, rvalid1}, 32'd0);
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    do_req("lw_50_after_reset", 1'b0, 32'h50, 32'h0, SIZE_W, 1'b0, 32'h12345678, 1'b0, 1'b0);

    // Reset while the response strobe is high drops it immediately.
    @(negedge clk);
    while (!ready1) @(negedge clk);
    req_i = 1'b1; we_i = 1'b1; addr_i = 32'h41; size_i = SIZE_W;
    @(posedge clk);
    @(negedge clk);
    req_i = 1'b0;
    @(negedge clk);
    check("resp strobe before reset", {31'd0, rvalid1}, 32'd1);
    rst = 1'b0;
    #1;
    check("resp strobe after reset", {31'd0, rvalid1}, 32'd0);
    check("resp err after reset", {31'd0, err1}, 32'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
